// File: rtl/srt4_pkg.sv
// -----------------------------------------------------------------------------
// srt4_pkg
// Shared definitions for the SRT radix-4 on-the-fly quotient converter.
//   state_t        : converter FSM state encoding
//   DIG_M2..DIG_P2 : 3-bit two's-complement quotient digit constants
//   is_legal_digit : true for digits in -2..2
// -----------------------------------------------------------------------------
package srt4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] DIG_M2 = 3'b110;
  localparam logic [2:0] DIG_M1 = 3'b111;
  localparam logic [2:0] DIG_Z  = 3'b000;
  localparam logic [2:0] DIG_P1 = 3'b001;
  localparam logic [2:0] DIG_P2 = 3'b010;

  function automatic logic is_legal_digit(input logic [2:0] d);
    return (d == DIG_M2) || (d == DIG_M1) || (d == DIG_Z) ||
           (d == DIG_P1) || (d == DIG_P2);
  endfunction

endpackage

// File: rtl/srt4_otf_step.sv
// -----------------------------------------------------------------------------
// srt4_otf_step
// Purely combinational on-the-fly conversion step: appends one radix-4 digit
// to the Q/QM register pair (QM always tracks Q - 1 at the current weight).
// Ports:
//   i_q, i_qm            : current Q and QM
//   i_d                  : legal digit -2..2, two's complement
//   o_q_next, o_qm_next  : Q and QM after appending i_d
// -----------------------------------------------------------------------------
module srt4_otf_step
  import srt4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_q,
  input  logic [W-1:0] i_qm,
  input  logic [2:0]   i_d,
  output logic [W-1:0] o_q_next,
  output logic [W-1:0] o_qm_next
);

  logic       w_d_neg;
  logic       w_d_pos;
  logic [1:0] w_lo_q;
  logic [1:0] w_lo_qm;

  assign w_d_neg = i_d[2];
  assign w_d_pos = !i_d[2] && (i_d != DIG_Z);

  // Low two bits are d mod 4 for Q and (d-1) mod 4 for QM; the borrow into the
  // upper digits is handled by picking QM instead of Q as the shifted prefix.
  assign w_lo_q  = i_d[1:0];
  assign w_lo_qm = i_d[1:0] - 2'd1;

  assign o_q_next  = ((w_d_neg ? i_qm : i_q) << 2) | {{(W-2){1'b0}}, w_lo_q};
  assign o_qm_next = ((w_d_pos ? i_q : i_qm) << 2) | {{(W-2){1'b0}}, w_lo_qm};

endmodule

// File: rtl/srt4_otf_converter.sv
// -----------------------------------------------------------------------------
// srt4_otf_converter
// Consumer end of the SRT radix-4 divider: converts MSD-first signed digits
// into a W-bit quotient on the fly and applies the final remainder-sign fix.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for i_start
//   CONV    | accepting digits, o_digit_ready=1
//   FIX     | awaiting remainder sign, o_fix_ready=1
//   DONE    | o_done=1, o_q holds corrected quotient
//
// Ports:
//   i_clk, i_rst_b       : clock, synchronous active-low reset
//   i_start              : start new conversion (wins over handshakes)
//   i_digit_valid/i_digit, o_digit_ready : digit handshake
//   i_fix_valid/i_rem_neg, o_fix_ready   : sign-correction handshake
//   o_q, o_done, o_err   : result, result valid, sticky illegal-digit flag
// -----------------------------------------------------------------------------
module srt4_otf_converter
  import srt4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_b,
  input  logic         i_start,
  input  logic         i_digit_valid,
  input  logic [2:0]   i_digit,
  output logic         o_digit_ready,
  input  logic         i_fix_valid,
  input  logic         i_rem_neg,
  output logic         o_fix_ready,
  output logic [W-1:0] o_q,
  output logic         o_done,
  output logic         o_err
);

  localparam int N     = W / 2;
  localparam int CNT_W = $clog2(N) + 1;

  generate
    if ((W % 2) != 0 || W < 4) begin : g_bad_w
      $error("srt4_otf_converter: W must be even and >= 4");
    end
  endgenerate

  state_t             r_state;
  logic [W-1:0]       r_qa;
  logic [W-1:0]       r_qm;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_q;
  logic               r_done;
  logic               r_err;

  logic               w_legal;
  logic [2:0]         w_d_eff;
  logic [W-1:0]       w_q_next;
  logic [W-1:0]       w_qm_next;

  // Illegal digits are folded to zero so Q/QM stay consistent.
  assign w_legal = is_legal_digit(i_digit);
  assign w_d_eff = w_legal ? i_digit : DIG_Z;

  srt4_otf_step #(.W(W)) u_step (
    .i_q       (r_qa),
    .i_qm      (r_qm),
    .i_d       (w_d_eff),
    .o_q_next  (w_q_next),
    .o_qm_next (w_qm_next)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_state <= ST_IDLE;
      r_qa    <= '0;
      r_qm    <= '1;
      r_cnt   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (i_start) begin
      r_state <= ST_CONV;
      r_qa    <= '0;
      r_qm    <= '1;
      r_cnt   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_CONV: begin
          if (i_digit_valid) begin
            r_qa  <= w_q_next;
            r_qm  <= w_qm_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (!w_legal) r_err <= 1'b1;
            if (r_cnt == CNT_W'(N - 1)) r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (i_fix_valid) begin
            r_q     <= i_rem_neg ? r_qm : r_qa;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_digit_ready = (r_state == ST_CONV);
  assign o_fix_ready   = (r_state == ST_FIX);
  assign o_q           = r_q;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule
